// File: rtl/dm_rom_pkg.sv
// dm_rom_pkg: debug ROM images, patch slot type and shared limits.
// Imported by dm_rom_ctrl and dm_rom_patch_table.
package dm_rom_pkg;

   localparam int MaxReadLatency = 3;

   localparam int RomOneScratchSize = 6;
   localparam int RomTwoScratchSize = 7;

   // Debug ROM image for a hart with one dscratch register.
   localparam logic [63:0] RomImgOneScratch [RomOneScratchSize] = '{
      64'h7b24_1073_0000_006f,
      64'h0010_0413_f140_2473,
      64'h1004_2023_0000_0517,
      64'h7b20_2473_1080_2023,
      64'h7b20_0073_1000_0023,
      64'h0000_0013_0ff0_000f
   };

   // Debug ROM image for a hart with two dscratch registers.
   localparam logic [63:0] RomImgTwoScratch [RomTwoScratchSize] = '{
      64'h7b34_1073_7b24_1073,
      64'h0010_0413_f140_2473,
      64'h1004_2023_0000_0417,
      64'h7b30_2473_7b20_2473,
      64'h1080_2023_0000_0013,
      64'h7b20_0073_1000_0023,
      64'h0000_0013_0ff0_000f
   };

   typedef struct packed {
      logic        valid;
      logic [7:0]  word;
      logic [63:0] data;
   } patch_entry_t;

   // Returns zero for an index past the end of the selected image;
   // callers gate that case with their own range check.
   function automatic logic [63:0] rom_lookup(
      input logic       two_scratch,
      input logic [7:0] idx
   );
      logic [63:0] w;
      w = '0;
      if (two_scratch) begin
         for (int i = 0; i < RomTwoScratchSize; i++) begin
            if (idx == 8'(i)) w = RomImgTwoScratch[i];
         end
      end else begin
         for (int i = 0; i < RomOneScratchSize; i++) begin
            if (idx == 8'(i)) w = RomImgOneScratch[i];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/dm_rom_patch_table.sv
// dm_rom_patch_table: patch slot storage with lowest-index-wins lookup.
// Ports: we/idx/word/data write a slot, clr_i invalidates all slots,
// lookup_word_i is matched against stored slots (hit_o, data_o).
module dm_rom_patch_table
   import dm_rom_pkg::*;
#(
   parameter int unsigned PatchEntries = 4,
   parameter int unsigned IdxW         = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [IdxW-1:0] idx_i,
   input  logic [7:0]      word_i,
   input  logic [63:0]     data_i,
   input  logic            clr_i,
   input  logic [7:0]      lookup_word_i,
   output logic            hit_o,
   output logic [63:0]     data_o
);

   patch_entry_t slots_q [PatchEntries];
   patch_entry_t slots_d [PatchEntries];

   // Clear has priority over a write in the same cycle.
   always_comb begin
      slots_d = slots_q;
      if (clr_i) begin
         for (int i = 0; i < int'(PatchEntries); i++) begin
            slots_d[i] = '0;
         end
      end else if (we_i) begin
         for (int i = 0; i < int'(PatchEntries); i++) begin
            if (idx_i == IdxW'(i)) begin
               slots_d[i].valid = 1'b1;
               slots_d[i].word  = word_i;
               slots_d[i].data  = data_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(PatchEntries); i++) begin
            slots_q[i] <= '0;
         end
      end else begin
         slots_q <= slots_d;
      end
   end

   // Lookup uses registered slots, so a write in the same cycle as a
   // read is not yet visible. Scanning downwards lets slot 0 win.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int i = int'(PatchEntries) - 1; i >= 0; i--) begin
         if (slots_q[i].valid && slots_q[i].word == lookup_word_i) begin
            hit_o  = 1'b1;
            data_o = slots_q[i].data;
         end
      end
   end

endmodule

// File: rtl/dm_rom_ctrl.sv
// dm_rom_ctrl: debug ROM read port (one/two-scratch images, 32/64b bus).
// Ports: req/addr/two_scratch in, gnt/rvalid/rdata/err out, patch_* writes.
// Optional patch table built when DM_ROM_PATCH_EN is defined.
module dm_rom_ctrl
   import dm_rom_pkg::*;
#(
   parameter int unsigned          BusWidth     = 64,
   parameter int unsigned          AddrWidth    = 64,
   parameter logic [AddrWidth-1:0] BaseAddr     = 'h800,
   parameter int unsigned          ReadLatency  = 1,
   parameter int unsigned          PatchEntries = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 two_scratch_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [BusWidth-1:0]  rdata_o,
   output logic                 err_o,
   input  logic                 patch_we_i,
   input  logic [((PatchEntries > 1) ? $clog2(PatchEntries) : 1)-1:0]
                                patch_idx_i,
   input  logic [7:0]           patch_word_i,
   input  logic [63:0]          patch_data_i,
   input  logic                 patch_clr_i
);

   localparam int unsigned PatchIdxW =
      (PatchEntries > 1) ? $clog2(PatchEntries) : 1;

   if (BusWidth != 32 && BusWidth != 64) begin : g_bad_bus
      $error("dm_rom_ctrl: BusWidth must be 32 or 64");
   end

   if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_lat
      $error("dm_rom_ctrl: ReadLatency must be 1..3");
   end

   logic [AddrWidth-1:0] off;
   logic                 under;
   logic                 in_range;
   logic                 misalign;
   logic                 acc_err;
   logic [7:0]           word_idx;
   logic [63:0]          rom_word;
   logic [63:0]          sel_word;
   logic [BusWidth-1:0]  acc_data;
   logic                 patch_hit;
   logic [63:0]          patch_data;

   assign gnt_o = req_i;

`ifdef DM_ROM_PATCH_EN
   dm_rom_patch_table #(
      .PatchEntries (PatchEntries),
      .IdxW         (PatchIdxW)
   ) u_patch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .we_i          (patch_we_i),
      .idx_i         (patch_idx_i),
      .word_i        (patch_word_i),
      .data_i        (patch_data_i),
      .clr_i         (patch_clr_i),
      .lookup_word_i (word_idx),
      .hit_o         (patch_hit),
      .data_o        (patch_data)
   );
`else
   logic unused_patch;
   assign unused_patch = ^{patch_we_i, patch_idx_i, patch_word_i,
                           patch_data_i, patch_clr_i};
   assign patch_hit  = 1'b0;
   assign patch_data = '0;
`endif

   // Acceptance-cycle decode. The offset wraps on underflow, so the
   // underflow flag is taken from the raw address compare.
   always_comb begin
      off      = addr_i - BaseAddr;
      under    = addr_i < BaseAddr;
      word_idx = off[10:3];
      if (two_scratch_i) begin
         in_range = (off >> 3) < AddrWidth'(RomTwoScratchSize);
      end else begin
         in_range = (off >> 3) < AddrWidth'(RomOneScratchSize);
      end
      if (BusWidth == 32) begin
         misalign = off[1:0] != 2'b00;
      end else begin
         misalign = off[2:0] != 3'b000;
      end
      acc_err  = under | ~in_range | misalign;
      rom_word = rom_lookup(two_scratch_i, word_idx);
      if (patch_hit) begin
         sel_word = patch_data;
      end else begin
         sel_word = rom_word;
      end
      if (acc_err) begin
         sel_word = '0;
      end
      if (BusWidth == 32) begin
         acc_data = BusWidth'(off[2] ? sel_word[63:32] : sel_word[31:0]);
      end else begin
         acc_data = BusWidth'(sel_word);
      end
   end

   logic [ReadLatency-1:0] valid_q;
   logic [ReadLatency-1:0] valid_d;
   logic [ReadLatency-1:0] err_q;
   logic [ReadLatency-1:0] err_d;
   logic [BusWidth-1:0]    data_q [ReadLatency];
   logic [BusWidth-1:0]    data_d [ReadLatency];

   // Valid and err shift every cycle; data stages only load behind a
   // valid beat so the output word holds between responses.
   always_comb begin
      valid_d   = valid_q;
      err_d     = err_q;
      data_d    = data_q;
      valid_d[0] = req_i;
      err_d[0]   = req_i & acc_err;
      if (req_i) begin
         data_d[0] = acc_data;
      end
      for (int i = 1; i < int'(ReadLatency); i++) begin
         valid_d[i] = valid_q[i-1];
         err_d[i]   = err_q[i-1];
         if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < int'(ReadLatency); i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign rvalid_o = valid_q[ReadLatency-1];
   assign err_o    = err_q[ReadLatency-1];
   assign rdata_o  = data_q[ReadLatency-1];

endmodule

// File: tb/tb_dm_rom_ctrl.sv
// tb_dm_rom_ctrl: directed bench for dm_rom_ctrl, three configurations
// (64b/lat1, 32b/lat2, 64b/lat3) sharing one request stream.
module tb_dm_rom_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [63:0] addr;
   logic        two;
   logic        p_we;
   logic [1:0]  p_idx;
   logic [7:0]  p_word;
   logic [63:0] p_data;
   logic        p_clr;

   logic        a_gnt, a_rvalid, a_err;
   logic [63:0] a_rdata;
   logic        b_gnt, b_rvalid, b_err;
   logic [31:0] b_rdata;
   logic        c_gnt, c_rvalid, c_err;
   logic [63:0] c_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dm_rom_ctrl #(.BusWidth(64), .ReadLatency(1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
      .two_scratch_i(two), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
      .rdata_o(a_rdata), .err_o(a_err), .patch_we_i(p_we),
      .patch_idx_i(p_idx), .patch_word_i(p_word),
      .patch_data_i(p_data), .patch_clr_i(p_clr)
   );

   dm_rom_ctrl #(.BusWidth(32), .ReadLatency(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
      .two_scratch_i(two), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
      .rdata_o(b_rdata), .err_o(b_err), .patch_we_i(p_we),
      .patch_idx_i(p_idx), .patch_word_i(p_word),
      .patch_data_i(p_data), .patch_clr_i(p_clr)
   );

   dm_rom_ctrl #(.BusWidth(64), .ReadLatency(3)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
      .two_scratch_i(two), .gnt_o(c_gnt), .rvalid_o(c_rvalid),
      .rdata_o(c_rdata), .err_o(c_err), .patch_we_i(p_we),
      .patch_idx_i(p_idx), .patch_word_i(p_word),
      .patch_data_i(p_data), .patch_clr_i(p_clr)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One single-beat read; returns the 64b/lat1 response.
   task automatic read_a(input logic [63:0] ad, input logic tw,
                         output logic v, output logic [63:0] d,
                         output logic e);
      req  = 1'b1;
      addr = ad;
      two  = tw;
      @(posedge clk); #1;
      req  = 1'b0;
      v = a_rvalid;
      d = a_rdata;
      e = a_err;
   endtask

   task automatic patch_wr(input logic [1:0] idx, input logic [7:0] w,
                           input logic [63:0] dat, input logic clr);
      p_we   = 1'b1;
      p_idx  = idx;
      p_word = w;
      p_data = dat;
      p_clr  = clr;
      @(posedge clk); #1;
      p_we  = 1'b0;
      p_clr = 1'b0;
   endtask

   typedef struct {
      logic [63:0] addr;
      logic        two;
      logic [63:0] d64;
      logic        e64;
      logic [31:0] d32;
      logic        e32;
   } vec_t;

   vec_t        vecs [12];
   logic [63:0] one_img [6];
   logic [63:0] two_img [7];

   initial begin
      logic        v, e;
      logic [63:0] d;

      one_img[0] = 64'h7b24_1073_0000_006f;
      one_img[1] = 64'h0010_0413_f140_2473;
      one_img[2] = 64'h1004_2023_0000_0517;
      one_img[3] = 64'h7b20_2473_1080_2023;
      one_img[4] = 64'h7b20_0073_1000_0023;
      one_img[5] = 64'h0000_0013_0ff0_000f;
      two_img[0] = 64'h7b34_1073_7b24_1073;
      two_img[1] = 64'h0010_0413_f140_2473;
      two_img[2] = 64'h1004_2023_0000_0417;
      two_img[3] = 64'h7b30_2473_7b20_2473;
      two_img[4] = 64'h1080_2023_0000_0013;
      two_img[5] = 64'h7b20_0073_1000_0023;
      two_img[6] = 64'h0000_0013_0ff0_000f;

      vecs[0]  = '{64'h800, 1'b0, 64'h7b24_1073_0000_006f, 1'b0, 32'h0000_006f, 1'b0};
      vecs[1]  = '{64'h804, 1'b0, 64'h0, 1'b1, 32'h7b24_1073, 1'b0};
      vecs[2]  = '{64'h810, 1'b1, 64'h1004_2023_0000_0417, 1'b0, 32'h0000_0417, 1'b0};
      vecs[3]  = '{64'h81c, 1'b0, 64'h0, 1'b1, 32'h7b20_2473, 1'b0};
      vecs[4]  = '{64'h7f8, 1'b0, 64'h0, 1'b1, 32'h0, 1'b1};
      vecs[5]  = '{64'h830, 1'b0, 64'h0, 1'b1, 32'h0, 1'b1};
      vecs[6]  = '{64'h830, 1'b1, 64'h0000_0013_0ff0_000f, 1'b0, 32'h0ff0_000f, 1'b0};
      vecs[7]  = '{64'h802, 1'b1, 64'h0, 1'b1, 32'h0, 1'b1};
      vecs[8]  = '{64'h838, 1'b1, 64'h0, 1'b1, 32'h0, 1'b1};
      vecs[9]  = '{64'h834, 1'b1, 64'h0, 1'b1, 32'h0000_0013, 1'b0};
      vecs[10] = '{64'hffff_ffff_0000_0800, 1'b0, 64'h0, 1'b1, 32'h0, 1'b1};
      vecs[11] = '{64'h828, 1'b0, 64'h0000_0013_0ff0_000f, 1'b0, 32'h0ff0_000f, 1'b0};

      rst_n  = 1'b0;
      req    = 1'b0;
      addr   = '0;
      two    = 1'b0;
      p_we   = 1'b0;
      p_idx  = '0;
      p_word = '0;
      p_data = '0;
      p_clr  = 1'b0;

      #1;
      chk("rst a_rvalid", 64'(a_rvalid), 64'd0);
      chk("rst a_rdata", a_rdata, 64'd0);
      chk("rst a_err", 64'(a_err), 64'd0);
      chk("rst b_rvalid", 64'(b_rvalid), 64'd0);
      chk("rst c_rvalid", 64'(c_rvalid), 64'd0);
      chk("rst c_rdata", c_rdata, 64'd0);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-read vectors, each DUT sampled at its own latency.
      for (int i = 0; i < 12; i++) begin
         req  = 1'b1;
         addr = vecs[i].addr;
         two  = vecs[i].two;
         chk($sformatf("v%0d gnt", i), 64'(a_gnt), 64'd1);
         @(posedge clk); #1;
         req  = 1'b0;
         addr = 64'h800;
         two  = ~vecs[i].two;
         chk($sformatf("v%0d a_rvalid", i), 64'(a_rvalid), 64'd1);
         chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].d64);
         chk($sformatf("v%0d a_err", i), 64'(a_err), 64'(vecs[i].e64));
         chk($sformatf("v%0d b_early", i), 64'(b_rvalid), 64'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d b_rvalid", i), 64'(b_rvalid), 64'd1);
         chk($sformatf("v%0d b_rdata", i), 64'(b_rdata), 64'(vecs[i].d32));
         chk($sformatf("v%0d b_err", i), 64'(b_err), 64'(vecs[i].e32));
         chk($sformatf("v%0d a_idle", i), 64'(a_rvalid), 64'd0);
         chk($sformatf("v%0d a_hold", i), a_rdata, vecs[i].d64);
         chk($sformatf("v%0d c_early", i), 64'(c_rvalid), 64'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d c_rvalid", i), 64'(c_rvalid), 64'd1);
         chk($sformatf("v%0d c_rdata", i), c_rdata, vecs[i].d64);
         chk($sformatf("v%0d c_err", i), 64'(c_err), 64'(vecs[i].e64));
         @(posedge clk); #1;
         chk($sformatf("v%0d c_idle", i), 64'(c_rvalid), 64'd0);
      end

      // Back-to-back burst over the whole one-scratch image.
      for (int c = 0; c < 9; c++) begin
         req  = (c < 6);
         addr = 64'h800 + 64'(8 * c);
         two  = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("b2b%0d a_v", c), 64'(a_rvalid), 64'(c < 6));
         if (c < 6) chk($sformatf("b2b%0d a_d", c), a_rdata, one_img[c]);
         chk($sformatf("b2b%0d b_v", c), 64'(b_rvalid), 64'(c >= 1 && c < 7));
         if (c >= 1 && c < 7)
            chk($sformatf("b2b%0d b_d", c), 64'(b_rdata), 64'(one_img[c-1][31:0]));
         chk($sformatf("b2b%0d c_v", c), 64'(c_rvalid), 64'(c >= 2 && c < 8));
         if (c >= 2 && c < 8)
            chk($sformatf("b2b%0d c_d", c), c_rdata, one_img[c-2]);
      end
      req = 1'b0;

      // Mode toggled between two in-flight reads of word 2.
      req  = 1'b1;
      addr = 64'h810;
      two  = 1'b0;
      @(posedge clk); #1;
      two = 1'b1;
      chk("mode a_first", a_rdata, one_img[2]);
      @(posedge clk); #1;
      req = 1'b0;
      two = 1'b0;
      chk("mode a_second", a_rdata, two_img[2]);
      @(posedge clk); #1;
      chk("mode c_first_v", 64'(c_rvalid), 64'd1);
      chk("mode c_first", c_rdata, one_img[2]);
      @(posedge clk); #1;
      chk("mode c_second_v", 64'(c_rvalid), 64'd1);
      chk("mode c_second", c_rdata, two_img[2]);
      @(posedge clk); #1;

`ifdef DM_ROM_PATCH_EN
      // Write and read of word 3 in one cycle: read sees old word.
      p_we   = 1'b1;
      p_idx  = 2'd1;
      p_word = 8'd3;
      p_data = 64'hdead_beef_0000_0013;
      read_a(64'h818, 1'b0, v, d, e);
      p_we = 1'b0;
      chk("patch same_cycle", d, one_img[3]);
      read_a(64'h818, 1'b0, v, d, e);
      chk("patch one_img", d, 64'hdead_beef_0000_0013);
      chk("patch one_err", 64'(e), 64'd0);
      read_a(64'h818, 1'b1, v, d, e);
      chk("patch two_img", d, 64'hdead_beef_0000_0013);
      patch_wr(2'd0, 8'd3, 64'h1111_2222_3333_4444, 1'b0);
      read_a(64'h818, 1'b0, v, d, e);
      chk("patch lowest_wins", d, 64'h1111_2222_3333_4444);
      patch_wr(2'd3, 8'd6, 64'h5555_6666_7777_8888, 1'b0);
      read_a(64'h830, 1'b0, v, d, e);
      chk("patch oor_err", 64'(e), 64'd1);
      chk("patch oor_data", d, 64'd0);
      read_a(64'h830, 1'b1, v, d, e);
      chk("patch w6_two", d, 64'h5555_6666_7777_8888);
      patch_wr(2'd2, 8'd0, 64'h9999_9999_9999_9999, 1'b1);
      read_a(64'h800, 1'b0, v, d, e);
      chk("patch clr_wins", d, one_img[0]);
      read_a(64'h818, 1'b0, v, d, e);
      chk("patch cleared", d, one_img[3]);
`else
      patch_wr(2'd1, 8'd3, 64'hdead_beef_0000_0013, 1'b0);
      read_a(64'h818, 1'b0, v, d, e);
      chk("nopatch valid", 64'(v), 64'd1);
      chk("nopatch word3", d, one_img[3]);
`endif

      // Reset while reads are in flight drops them.
      req  = 1'b1;
      addr = 64'h808;
      two  = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rstmid c_rvalid", 64'(c_rvalid), 64'd0);
      chk("rstmid c_rdata", c_rdata, 64'd0);
      chk("rstmid a_rvalid", 64'(a_rvalid), 64'd0);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rstmid%0d b_rvalid", k), 64'(b_rvalid), 64'd0);
         chk($sformatf("rstmid%0d c_rvalid", k), 64'(c_rvalid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
